control_unit_fft_iter_pipe: RTL and testbench

Pipelined control unit for the iterative in-place FFT core. It issues one butterfly read per enabled cycle and generates write-back strobes delayed by a parameterised memory-plus-butterfly latency. Each layer drains fully before the next layer starts, which removes in-place read/write hazards. Transform depth is selected at run time, and the block provides BUSY/DONE/ABORT handshakes to the top-level FFT sequencer.

---
 rtl/control_unit_fft_iter_pipe.sv | 142 ++++++++++++++
 tb/tb_control_unit_fft_iter_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fft_iter_pipe.sv
// Pipelined read/write-back sequencer for the iterative in-place FFT core.
// Reads one butterfly per enabled cycle and drains each layer before starting the next.
module control_unit_fft_iter_pipe #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int RD_LAT      = 1,
  parameter int BUT_LAT     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LayWL-1:0]  lay_num_i,
  output logic              rd_en_o,
  output logic [ButtWL-1:0] rd_but_o,
  output logic [LayWL-1:0]  rd_lay_o,
  output logic              first_o,
  output logic              wr_en_o,
  output logic [ButtWL-1:0] wr_but_o,
  output logic [LayWL-1:0]  wr_lay_o,
  output logic              lay_en_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PIPE  = RD_LAT + BUT_LAT;
  localparam int CntWL = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [ButtWL-1:0] LastBut   = ButtWL'(BUTTERFLYES - 1);
  localparam logic [LayWL-1:0]  MaxLay    = LayWL'(LAYERS);
  localparam logic [CntWL-1:0]  LastDrain = CntWL'(PIPE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q;
  logic              rdEn_q;
  logic [ButtWL-1:0] rdBut_q;
  logic [LayWL-1:0]  rdLay_q;
  logic [LayWL-1:0]  nl_q;
  logic [LayWL-1:0]  nl_d;
  logic [CntWL-1:0]  drainCnt_q;
  logic              done_q;
  logic              pipeVld_q [PIPE];
  logic [ButtWL-1:0] pipeBut_q [PIPE];
  logic [LayWL-1:0]  pipeLay_q [PIPE];

  // A zero or out-of-range depth request falls back to the full transform.
  always_comb begin
    nl_d = lay_num_i;
    if (lay_num_i == '0 || lay_num_i > MaxLay) nl_d = MaxLay;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rdEn_q     <= 1'b0;
      rdBut_q    <= '0;
      rdLay_q    <= '0;
      nl_q       <= MaxLay;
      drainCnt_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < PIPE; i++) begin
        pipeVld_q[i] <= 1'b0;
        pipeBut_q[i] <= '0;
        pipeLay_q[i] <= '0;
      end
    end else if (abort_i) begin
      state_q    <= IDLE;
      rdEn_q     <= 1'b0;
      drainCnt_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < PIPE; i++) begin
        pipeVld_q[i] <= 1'b0;
        pipeBut_q[i] <= '0;
        pipeLay_q[i] <= '0;
      end
    end else if (en_i) begin
      pipeVld_q[0] <= rdEn_q;
      pipeBut_q[0] <= rdBut_q;
      pipeLay_q[0] <= rdLay_q;
      for (int i = 1; i < PIPE; i++) begin
        pipeVld_q[i] <= pipeVld_q[i-1];
        pipeBut_q[i] <= pipeBut_q[i-1];
        pipeLay_q[i] <= pipeLay_q[i-1];
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            nl_q       <= nl_d;
            rdBut_q    <= '0;
            rdLay_q    <= '0;
            drainCnt_q <= '0;
            rdEn_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (rdBut_q == LastBut) begin
            rdEn_q     <= 1'b0;
            drainCnt_q <= '0;
            state_q    <= DRAIN;
          end else begin
            rdBut_q <= rdBut_q + ButtWL'(1);
          end
        end
        // After PIPE drain cycles the last write of the layer is on the outputs.
        DRAIN: begin
          if (drainCnt_q == LastDrain) begin
            drainCnt_q <= '0;
            if (rdLay_q < nl_q - LayWL'(1)) begin
              rdLay_q <= rdLay_q + LayWL'(1);
              rdBut_q <= '0;
              rdEn_q  <= 1'b1;
              state_q <= ISSUE;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end else begin
            drainCnt_q <= drainCnt_q + CntWL'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en_o  = rdEn_q & en_i;
  assign rd_but_o = rdBut_q;
  assign rd_lay_o = rdLay_q;
  assign first_o  = rd_en_o && (rdLay_q == '0);
  assign wr_en_o  = pipeVld_q[PIPE-1] & en_i;
  assign wr_but_o = pipeBut_q[PIPE-1];
  assign wr_lay_o = pipeLay_q[PIPE-1];
  assign lay_en_o = wr_en_o && (wr_but_o == LastBut);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q & en_i;

endmodule

// File: tb/tb_control_unit_fft_iter_pipe.sv
// Directed bench: a 4-butterfly, 2-layer instance against a hand-derived cycle
// table, plus a default-sized instance checked by event counts.
module tb_control_unit_fft_iter_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       abort = 1'b0;
  logic       startA = 1'b0;
  logic       startB = 1'b0;
  logic [2:0] layNumA = 3'd2;
  logic [2:0] layNumB = 3'd0;

  logic       rdEnA, firstA, wrEnA, layEnA, busyA, doneA;
  logic [1:0] rdButA, wrButA;
  logic [2:0] rdLayA, wrLayA;
  logic       rdEnB, firstB, wrEnB, layEnB, busyB, doneB;
  logic [3:0] rdButB, wrButB;
  logic [2:0] rdLayB, wrLayB;

  int total = 0;
  int bad = 0;
  int seqT = 0;
  bit zeroIdx = 1'b1;
  int reads, writes, layEns, firsts, doneAt;

  always #5 clk = ~clk;

  control_unit_fft_iter_pipe #(
    .LAYERS(5), .BUTTERFLYES(4), .LayWL(3), .ButtWL(2), .RD_LAT(1), .BUT_LAT(2)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(startA), .abort_i(abort),
    .lay_num_i(layNumA), .rd_en_o(rdEnA), .rd_but_o(rdButA), .rd_lay_o(rdLayA),
    .first_o(firstA), .wr_en_o(wrEnA), .wr_but_o(wrButA), .wr_lay_o(wrLayA),
    .lay_en_o(layEnA), .busy_o(busyA), .done_o(doneA)
  );

  control_unit_fft_iter_pipe dutB (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(startB), .abort_i(abort),
    .lay_num_i(layNumB), .rd_en_o(rdEnB), .rd_but_o(rdButB), .rd_lay_o(rdLayB),
    .first_o(firstB), .wr_en_o(wrEnB), .wr_but_o(wrButB), .wr_lay_o(wrLayB),
    .lay_en_o(layEnB), .busy_o(busyB), .done_o(doneB)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s seqT=%0d observed=%0d expected=%0d", tag, seqT, obs, exp);
    end
  endtask

  // Inputs for a cycle are driven just after the edge that opens it and sampled at the next edge.
  task automatic applyStimulus(input bit s, input bit sB, input bit a, input bit e, input bit r);
    @(posedge clk);
    #1;
    startA = s;
    startB = sB;
    abort  = a;
    en     = e;
    rst    = r;
    #1;
  endtask

  // Expected outputs of the 2-layer run, indexed by enabled cycles since START.
  task automatic step(input bit s, input bit a, input bit e, input bit r);
    int t;
    bit eRd, eWr;
    applyStimulus(s, 1'b0, a, e, r);
    t   = seqT;
    eRd = (t >= 1 && t <= 4) || (t >= 8 && t <= 11);
    eWr = (t >= 4 && t <= 7) || (t >= 11 && t <= 14);
    checkOutput("rd_en", rdEnA, int'(eRd & e));
    checkOutput("first", firstA, int'((t >= 1 && t <= 4) & e));
    checkOutput("wr_en", wrEnA, int'(eWr & e));
    checkOutput("lay_en", layEnA, int'((t == 7 || t == 14) & e));
    checkOutput("done", doneA, int'((t == 15) & e));
    checkOutput("busy", busyA, int'(t >= 1 && t <= 14));
    if (eRd) begin
      checkOutput("rd_but", rdButA, (t <= 4) ? t - 1 : t - 8);
      checkOutput("rd_lay", rdLayA, (t >= 8) ? 1 : 0);
    end
    if (eWr) begin
      checkOutput("wr_but", wrButA, (t <= 7) ? t - 4 : t - 11);
      checkOutput("wr_lay", wrLayA, (t >= 11) ? 1 : 0);
    end
    if (zeroIdx) begin
      checkOutput("rst_rd_but", rdButA, 0);
      checkOutput("rst_rd_lay", rdLayA, 0);
      checkOutput("rst_wr_but", wrButA, 0);
      checkOutput("rst_wr_lay", wrLayA, 0);
    end
    if (r) begin
      seqT = 0;
      zeroIdx = 1'b1;
    end else if (a) begin
      seqT = 0;
    end else if (e) begin
      if ((seqT == 0 || seqT == 15) && s) begin
        seqT = 1;
        zeroIdx = 1'b0;
      end else if (seqT >= 1 && seqT <= 14) begin
        seqT++;
      end else begin
        seqT = 0;
      end
    end
  endtask

  task automatic countRunA(input logic [2:0] ln);
    layNumA = ln;
    reads = 0; writes = 0; layEns = 0; firsts = 0; doneAt = -1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 120 && doneAt < 0; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      reads  += int'(rdEnA);
      writes += int'(wrEnA);
      layEns += int'(layEnA);
      firsts += int'(firstA);
      if (doneA === 1'b1) doneAt = c;
    end
  endtask

  task automatic countRunB();
    reads = 0; writes = 0; layEns = 0; firsts = 0; doneAt = -1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 200 && doneAt < 0; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      reads  += int'(rdEnB);
      writes += int'(wrEnB);
      layEns += int'(layEnB);
      firsts += int'(firstB);
      if (doneB === 1'b1) doneAt = c;
    end
  endtask

  initial begin
    // Reset state
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);

    // Nominal run; a new START lands in the DONE cycle
    step(1, 0, 1, 0);
    for (int i = 1; i <= 14; i++) step(0, 0, 1, 0);
    step(1, 0, 1, 0);

    // Second run: EN low for three cycles, START pulsed while busy
    for (int i = 1; i <= 21; i++) step(i == 12, 0, !(i >= 2 && i <= 4), 0);

    // Abort during the first drain, then a clean restart
    step(1, 0, 1, 0);
    for (int i = 1; i <= 20; i++) step(0, i == 6, 1, 0);
    step(1, 0, 1, 0);
    for (int i = 1; i <= 17; i++) step(0, 0, 1, 0);

    // Reset during the first drain, then a clean restart
    step(1, 0, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, i == 6);
    step(1, 0, 1, 0);
    for (int i = 1; i <= 17; i++) step(0, 0, 1, 0);

    // Out-of-range and zero depth both clamp to 5 layers
    countRunA(3'd7);
    checkOutput("clamp7_done_at", doneAt, 36);
    checkOutput("clamp7_reads", reads, 20);
    checkOutput("clamp7_writes", writes, 20);
    checkOutput("clamp7_lay_en", layEns, 5);
    checkOutput("clamp7_first", firsts, 4);
    applyStimulus(0, 0, 0, 1, 0);
    countRunA(3'd0);
    checkOutput("clamp0_done_at", doneAt, 36);
    checkOutput("clamp0_lay_en", layEns, 5);
    checkOutput("clamp0_busy_after", busyA, 0);

    // Default-sized instance with LAY_NUM=0
    countRunB();
    checkOutput("dflt_done_at", doneAt, 96);
    checkOutput("dflt_reads", reads, 80);
    checkOutput("dflt_writes", writes, 80);
    checkOutput("dflt_lay_en", layEns, 5);
    checkOutput("dflt_first", firsts, 16);
    checkOutput("dflt_busy_at_done", busyB, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("dflt_done_pulse", doneB, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
